// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and lane/extension helpers for the data-memory responder.
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Request attributes held from acceptance until the RAM access.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } req_attr_t;

  // Little-endian byte-lane enables for an access of the given size/offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << ofs;
      SZ_HALF: lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data onto every lane it may occupy.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_lanes = {4{wdata[7:0]}};
      SZ_HALF: store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] ofs, input logic is_unsigned);
    logic [31:0] sh;
    sh = word >> {ofs, 3'b000};
    case (size)
      SZ_BYTE: load_extend = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module data_mem_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // One access per enable: write the enabled lanes, or register the word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the pipeline's data-memory interface: valid/ready request and
// response channels, fixed wait-state latency, byte/half/word access with errors.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  req_attr_t         attr_q;

  logic              accept;
  logic              access;
  logic [ADDR_W-1:0] cur_addr;
  req_attr_t         cur_attr;
  logic              err_c;

  logic [31:0]       ram_rdata;
  logic              load_ok_q;
  logic [1:0]        size_q;
  logic [1:0]        ofs_q;
  logic              uns_q;

  assign accept = (state_q == ST_IDLE) && req_ready && req_valid && !reset;

  // With zero latency the access uses the live request on its acceptance edge.
  assign cur_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign cur_attr = (state_q == ST_IDLE) ? req_attr_t'{req_write, req_size, req_unsigned, req_wdata}
                                         : attr_q;

  assign access = !reset && (((LATENCY == 0) && accept) ||
                             ((state_q == ST_WAIT) && (cnt_q == '0)));

  // Misaligned, illegal size or out-of-range access on the request being serviced.
  assign err_c = (cur_attr.size == 2'b11) ||
                 ({1'b0, cur_addr} >= ADDR_LIMIT) ||
                 ((cur_attr.size == SZ_HALF) && cur_addr[0]) ||
                 ((cur_attr.size == SZ_WORD) && (cur_addr[1:0] != 2'b00));

  data_mem_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (access && !err_c),
    .we    (cur_attr.write),
    .be    (lane_mask(cur_attr.size, cur_addr[1:0])),
    .idx   (cur_addr[IDX_W+1:2]),
    .wdata (store_lanes(cur_attr.size, cur_attr.wdata)),
    .rdata (ram_rdata)
  );

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr;
      attr_q <= req_attr_t'{req_write, req_size, req_unsigned, req_wdata};
    end
  end

  // Registered handshake outputs and the response attributes latched at access.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      load_ok_q  <= 1'b0;
      size_q     <= SZ_BYTE;
      ofs_q      <= 2'b00;
      uns_q      <= 1'b0;
    end else begin
      req_ready  <= (state_d == ST_IDLE);
      resp_valid <= (state_d == ST_RESP);
      if (access) begin
        resp_err  <= err_c;
        load_ok_q <= !err_c && !cur_attr.write;
        size_q    <= cur_attr.size;
        ofs_q     <= cur_addr[1:0];
        uns_q     <= cur_attr.is_unsigned;
      end
    end
  end

  // Load data from the RAM's read register; zero for stores, errors and after reset.
  assign resp_rdata = load_ok_q ? load_extend(ram_rdata, size_q, ofs_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder with a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int LIMIT = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_write0, req_unsigned0;
  logic [1:0]  req_size0;
  logic [31:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_ready0, resp_err0;
  logic [31:0] resp_rdata0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mm [LIMIT];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          hold_low = 1'b0;
  bit          in_resp = 1'b0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_size(req_size0), .req_unsigned(req_unsigned0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_valid(resp_valid0),
    .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Random response backpressure unless a test forces it low.
  always @(posedge clk) begin
    #1;
    resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, rules computed arithmetically.
  function automatic void model(input bit wr, input logic [1:0] sz, input bit uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] d, output bit e);
    int nb;
    longint v;
    e = (sz == 2'd3) || (a >= 32'(LIMIT)) || (sz == 2'd1 && a % 2 != 0) ||
        (sz == 2'd2 && a % 4 != 0);
    d = 32'h0;
    if (e) return;
    nb = 1 << sz;
    if (wr) begin
      for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(mm[int'(a) + i]) << (8 * i));
      if (!uns && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
      d = 32'(v);
    end
  endfunction

  // Monitor: latency on first assertion, data/err on handshake.
  always @(negedge clk) begin
    if (reset) begin
      in_resp = 1'b0;
    end else if (resp_valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp at cycle %0d, required no response", cyc);
        end else begin
          chk("latency", 32'(cyc), 32'(exp_q[0].acc_cyc + 1 + LAT));
        end
      end
      if (resp_ready) begin
        if (exp_q.size() != 0) begin
          exp_t it;
          it = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, it.rdata);
          chk("resp_err", 32'(resp_err), 32'(it.err));
        end
        in_resp = 1'b0;
      end
    end
  end

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit track);
    int n;
    exp_t it;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout addr=0x%08h, required acceptance", a);
    end else if (track) begin
      it.acc_cyc = cyc;
      model(wr, sz, uns, a, wd, it.rdata, it.err);
      exp_q.push_back(it);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_write = 1'($urandom); req_unsigned = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready0"}, 32'(req_ready), 32'h0);
    chk({tag, "_resp_valid0"}, 32'(resp_valid), 32'h0);
    chk({tag, "_resp_rdata0"}, resp_rdata, 32'h0);
    chk({tag, "_resp_err0"}, 32'(resp_err), 32'h0);
  endtask

  // Zero-latency instance: one request, response expected the cycle after acceptance.
  task automatic req0(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                      input logic [31:0] wd, input string name,
                      input logic [31:0] exp_d, input bit exp_e);
    int n;
    @(posedge clk); #1;
    req_valid0 = 1'b1; req_write0 = wr; req_size0 = sz; req_unsigned0 = uns;
    req_addr0 = a; req_wdata0 = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready0 && n < 50);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid0 && n < 50);
    chk({name, "_lat"}, 32'(n), 32'd1);
    chk({name, "_rdata"}, resp_rdata0, exp_d);
    chk({name, "_err"}, 32'(resp_err0), 32'(exp_e));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; resp_ready = 1'b0; resp_ready0 = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55AA55AA;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_size0 = 2'd0; req_unsigned0 = 1'b0;
    req_addr0 = 32'h0; req_wdata0 = 32'h0;
    for (int i = 0; i < LIMIT; i++) mm[i] = 8'h00;

    // Reset with req_valid held high: no acceptance, outputs zero, ready one cycle later.
    repeat (4) @(posedge clk);
    #1 reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_dut0_req_ready", 32'(req_ready0), 32'h0);
    chk("rst_dut0_resp_valid", 32'(resp_valid0), 32'h0);
    @(negedge clk);
    chk("rst_req_ready1", 32'(req_ready), 32'h1);
    chk("rst_dut0_req_ready1", 32'(req_ready0), 32'h1);

    // Prefill every word the random phase may load.
    for (int a = 0; a < 128; a += 4) do_req(1, 2'd2, 0, 32'(a), $urandom, 1);
    do_req(1, 2'd2, 0, 32'(LIMIT - 8), $urandom, 1);
    do_req(1, 2'd2, 0, 32'(LIMIT - 4), $urandom, 1);

    // Directed word/byte/half accesses and error cases.
    do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 1);
    do_req(0, 2'd0, 0, 32'h13, 32'h0, 1);
    do_req(0, 2'd0, 1, 32'h13, 32'h0, 1);
    do_req(1, 2'd0, 0, 32'h11, 32'h0000005A, 1);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 1);
    do_req(1, 2'd1, 0, 32'h22, 32'h00008001, 1);
    do_req(0, 2'd1, 0, 32'h22, 32'h0, 1);
    do_req(0, 2'd1, 1, 32'h22, 32'h0, 1);
    do_req(0, 2'd2, 0, 32'h12, 32'h0, 1);
    do_req(1, 2'd1, 0, 32'h21, 32'h0000FFFF, 1);
    do_req(0, 2'd2, 0, 32'h20, 32'h0, 1);
    do_req(0, 2'd2, 0, 32'(LIMIT), 32'h0, 1);
    do_req(1, 2'd2, 0, 32'(LIMIT), 32'h12345678, 1);
    do_req(0, 2'd3, 0, 32'h10, 32'h0, 1);
    wait_drain();

    // Backpressure: response holds, and a new request is not accepted.
    hold_low = 1'b1;
    repeat (2) @(posedge clk);
    do_req(0, 2'd0, 0, 32'h13, 32'h0, 1);
    begin
      int n;
      n = 0;
      while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10;
    req_wdata = 32'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      if (exp_q.size() != 0) begin
        chk("bp_rdata", resp_rdata, exp_q[0].rdata);
        chk("bp_err", 32'(resp_err), 32'(exp_q[0].err));
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    hold_low = 1'b0;
    wait_drain();
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 1);

    // Reset during WAIT of a store: no write occurs.
    do_req(1, 2'd2, 0, 32'h30, 32'h11112222, 1);
    wait_drain();
    do_req(1, 2'd2, 0, 32'h30, 32'h99999999, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("wrst");
    @(negedge clk);
    chk("wrst_req_ready1", 32'(req_ready), 32'h1);
    do_req(0, 2'd2, 0, 32'h30, 32'h0, 1);

    // Randomised traffic.
    for (int t = 0; t < 80; t++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 127));
      else if (r == 8) a = 32'(LIMIT - 8 + $urandom_range(0, 7));
      else             a = 32'(LIMIT + $urandom_range(0, 7));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1);
    end
    wait_drain();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    // Zero-latency instance.
    req0(1, 2'd2, 0, 32'h40, 32'h12345678, "l0_st_word", 32'h0, 0);
    req0(0, 2'd2, 0, 32'h40, 32'h0, "l0_ld_word", 32'h12345678, 0);
    req0(0, 2'd0, 0, 32'h43, 32'h0, "l0_ld_byte", 32'h00000012, 0);
    req0(1, 2'd2, 0, 32'h44, 32'h8765CAFE, "l0_st_word2", 32'h0, 0);
    req0(0, 2'd1, 0, 32'h44, 32'h0, "l0_ld_half_s", 32'hFFFFCAFE, 0);
    req0(0, 2'd1, 1, 32'h46, 32'h0, "l0_ld_half_u", 32'h00008765, 0);
    req0(0, 2'd2, 0, 32'h46, 32'h0, "l0_misaligned", 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the pipeline's data-memory interface: services load/store requests issued by the memory stage.
- Uses a valid/ready request channel and a valid/ready response channel, with configurable wait-state latency.
- Contains a word-organised data RAM with byte/half/word access and sign/zero extension on loads.
- Flags misaligned and out-of-range accesses so the pipeline can stall, complete or trap deterministically.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; the byte address range is 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, wait cycles between request acceptance and response assertion; legal range 0..15.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load result, extended per size/unsigned; 0 for stores and errors.
- resp_err  out  1  misaligned, out of range, or size 11.

Behaviour:
- Reset: on a synchronous reset, outputs go to req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0. The FSM moves to IDLE on the next cycle, where req_ready=1. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is captured: addr, size, write, unsigned, wdata.
  - If LATENCY=0 the FSM goes to RESP; otherwise it goes to WAIT with cnt=LATENCY-1.
- WAIT:
  - req_ready=0.
  - cnt decrements each cycle; when cnt=0 the FSM goes to RESP.
- RAM access happens exactly once, on the cycle the FSM enters RESP.
  - Stores write the enabled byte lanes.
  - Loads register the extended data into resp_rdata.
- RESP:
  - resp_valid=1; resp_rdata and resp_err hold stable until resp_ready.
  - On resp_ready the FSM returns to IDLE, and resp_valid drops on the next cycle.
  - No back-to-back acceptance while in RESP.
- Latency: acceptance at cycle T gives resp_valid first high at T+1+LATENCY.
- Error checks are evaluated on the captured request:
  - size 01 with addr[0]!=0 is an error.
  - size 10 with addr[1:0]!=0 is an error.
  - size 11 is an error.
  - addr >= 4*DEPTH_WORDS is an error.
  - On error there is no RAM write, resp_rdata=0 and resp_err=1; the latency is unchanged.
- Byte lanes (little-endian):
  - byte: lane addr[1:0], data from wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1}, data from wdata[15:0].
  - word: all four lanes.
- Load extension: the selected byte/half is shifted to bit 0, then sign-extended from bit 7/15 unless req_unsigned.
- Request inputs are ignored when req_ready=0; the captured copy is used throughout.
- Reset mid-operation: any pending access is dropped. If reset arrives in WAIT, no write occurs. If reset arrives in RESP, the write has already completed and remains.
- A simultaneous req_valid and reset gives no acceptance.
- Read-after-write: a load accepted after a store's response sees the stored data.

Decomposition:
- Shared package holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encodings.
- Sub-module data_mem_lane_ram: DEPTH_WORDS x 32 synchronous RAM with 4 byte-write enables and a registered read.

Test Plan:
- Word store then load: store addr 0x10, wdata 0xDEADBEEF, then load word 0x10 → resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 1+LATENCY cycles after each acceptance.
- Byte lanes and extension:
  - After the word store above, load byte 0x13 signed → 0xFFFFFFDE.
  - Load byte 0x13 unsigned → 0x000000DE.
  - Store byte 0x11 = 0x5A, then load word 0x10 → 0xDEAD5AEF.
- Half access: store half 0x22 = 0x8001, then load half 0x22 signed → 0xFFFF8001; unsigned → 0x00008001.
- Errors:
  - Load word at 0x12 → resp_err=1, resp_rdata=0.
  - Store half at 0x21 → resp_err=1, and a following word load of 0x20 shows no change.
  - Address 4*DEPTH_WORDS → resp_err=1.
  - Size 11 → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0. A new req_valid during that window is not accepted.
- Reset:
  - Assert reset in WAIT of a store to 0x30 → no write; a later load of 0x30 returns the prior value.
  - Outputs are 0 the cycle after reset; req_ready=1 one cycle after reset deasserts.
  - Repeat with LATENCY=0 → response the cycle after acceptance.
